// File: rtl/pixel_sreg_ctrl_if.sv
// Handshake/data bundle for pixel_sreg_ctrl: readout and config requests in,
// serial channels, parity, committed config and status out.
interface pixel_sreg_ctrl_if #(
  parameter int PIX_BITS = 42,
  parameter int N_CH     = 2
);
  logic                start_read;
  logic                start_cfg;
  logic                abort;
  logic [PIX_BITS-1:0] pixel_in;
  logic                serial_in;
  logic [N_CH-1:0]     sreg_out;
  logic                out_valid;
  logic [N_CH-1:0]     parity_out;
  logic                parity_valid;
  logic [PIX_BITS-1:0] cfg_out;
  logic                busy;
  logic                done;

  modport master (
    output start_read, start_cfg, abort, pixel_in, serial_in,
    input  sreg_out, out_valid, parity_out, parity_valid, cfg_out, busy, done
  );

  modport slave (
    input  start_read, start_cfg, abort, pixel_in, serial_in,
    output sreg_out, out_valid, parity_out, parity_valid, cfg_out, busy, done
  );
endinterface

// File: rtl/pixel_sreg_ctrl.sv
// Pixel shift-register controller: N_CH-channel parallel readout and serial config load.
// Define PIXEL_SREG_PARITY_EN to add a per-channel even-parity beat after readout.
module pixel_sreg_ctrl #(
  parameter int                  PIX_BITS = 42,
  parameter int                  N_CH     = 2,
  parameter logic [PIX_BITS-1:0] CFG_RST  = '0
) (
  input  logic               sclk,
  input  logic               rst,
  pixel_sreg_ctrl_if.slave   bus
);
  localparam int SEG = PIX_BITS / N_CH;
  localparam int CW  = $clog2(PIX_BITS);
  localparam logic [CW-1:0] SEG_LAST = CW'(SEG - 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(PIX_BITS - 1);

`ifdef PIXEL_SREG_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, CFG} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, CFG} state_t;
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PIX_BITS-1:0] sreg_q, sreg_d;
  logic [PIX_BITS-1:0] cfg_q, cfg_d;
  logic                done_q, done_d;
  logic [N_CH-1:0]     sout;
  logic [PIX_BITS-1:0] sreg_cfg;

  // Each channel taps the MSB of its own SEG-bit slice.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign sout[k] = sreg_q[(k+1)*SEG-1];
  end

  assign sreg_cfg = {sreg_q[PIX_BITS-2:0], bus.serial_in};

`ifdef PIXEL_SREG_PARITY_EN
  logic [N_CH-1:0] par_q, par_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    cfg_d     = cfg_q;
    done_d    = 1'b0;
`ifdef PIXEL_SREG_PARITY_EN
    par_d     = par_q;
`endif
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_read) begin
            sreg_d    = bus.pixel_in;
            bit_cnt_d = '0;
            state_d   = SHIFT;
`ifdef PIXEL_SREG_PARITY_EN
            par_d     = '0;
`endif
          end else if (bus.start_cfg) begin
            bit_cnt_d = '0;
            state_d   = CFG;
          end
        end
        SHIFT: begin
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef PIXEL_SREG_PARITY_EN
          par_d     = par_q ^ sout;
          if (bit_cnt_q == SEG_LAST) state_d = PAR;
`else
          if (bit_cnt_q == SEG_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`endif
        end
`ifdef PIXEL_SREG_PARITY_EN
        PAR: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
        CFG: begin
          sreg_d    = sreg_cfg;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == PIX_LAST) begin
            cfg_d   = sreg_cfg;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      cfg_q     <= CFG_RST;
      done_q    <= 1'b0;
`ifdef PIXEL_SREG_PARITY_EN
      par_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      cfg_q     <= cfg_d;
      done_q    <= done_d;
`ifdef PIXEL_SREG_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.sreg_out  = sout;
  assign bus.out_valid = (state_q == SHIFT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.cfg_out   = cfg_q;
`ifdef PIXEL_SREG_PARITY_EN
  assign bus.parity_valid = (state_q == PAR);
  assign bus.parity_out   = (state_q == PAR) ? par_q : '0;
`else
  assign bus.parity_valid = 1'b0;
  assign bus.parity_out   = '0;
`endif
endmodule
